// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - shared fixed-point types, saturating helpers and LSM evaluator states
package fpga_cfg_pkg;

    localparam int FP_WIDTH = 32;
    localparam int FP_QFRAC = 16;

    typedef logic signed [FP_WIDTH-1:0]   fx_t;
    typedef logic signed [2*FP_WIDTH-1:0] fx_wide_t;

    localparam fx_t FX_MAX = {1'b0, {(FP_WIDTH-1){1'b1}}};
    localparam fx_t FX_MIN = {1'b1, {(FP_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        WAIT_BETA,
        RUN,
        DRAIN
    } lsm_eval_state_e;

    function automatic fx_t fx_sat(input fx_wide_t v);
        fx_wide_t hi;
        fx_wide_t lo;
        hi = fx_wide_t'(FX_MAX);
        lo = fx_wide_t'(FX_MIN);
        if (v > hi) begin
            return FX_MAX;
        end else if (v < lo) begin
            return FX_MIN;
        end
        return v[FP_WIDTH-1:0];
    endfunction

    // One guard bit is enough for a two-operand sum to never wrap before clamping.
    function automatic fx_t fx_add(input fx_t a, input fx_t b);
        logic signed [FP_WIDTH:0] s;
        s = {a[FP_WIDTH-1], a} + {b[FP_WIDTH-1], b};
        return fx_sat(fx_wide_t'(s));
    endfunction

    // Arithmetic shift floors the product, so negative fractions round toward minus infinity.
    function automatic fx_t fx_mul_trunc(input fx_t a, input fx_t b, input int qfrac);
        fx_wide_t p;
        p = a * b;
        return fx_sat(p >>> qfrac);
    endfunction

endpackage

// File: rtl/horner_quad_pipe.sv
// rtl/horner_quad_pipe.sv - two-stage stallable C = b0 + S*(b1 + b2*S) evaluator with sideband
module horner_quad_pipe
    import fpga_cfg_pkg::*;
#(
    parameter int QFRAC = FP_QFRAC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic adv,
    input  logic in_valid,
    input  fx_t  s,
    input  fx_t  payoff,
    input  fx_t  cont,
    input  fx_t  beta0,
    input  fx_t  beta1,
    input  fx_t  beta2,
    output logic out_valid,
    output fx_t  c,
    output fx_t  payoff_q,
    output fx_t  cont_q
);

    logic v1;
    fx_t  s1;
    fx_t  t1;
    fx_t  pay1;
    fx_t  cont1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            s1    <= '0;
            t1    <= '0;
            pay1  <= '0;
            cont1 <= '0;
        end else if (adv) begin
            v1    <= in_valid;
            s1    <= s;
            t1    <= fx_add(beta1, fx_mul_trunc(beta2, s, QFRAC));
            pay1  <= payoff;
            cont1 <= cont;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
            payoff_q  <= '0;
            cont_q    <= '0;
        end else if (adv) begin
            out_valid <= v1;
            c         <= fx_add(beta0, fx_mul_trunc(s1, t1, QFRAC));
            payoff_q  <= pay1;
            cont_q    <= cont1;
        end
    end

endmodule

// File: rtl/lsm_exercise_eval.sv
// rtl/lsm_exercise_eval.sv - per-date LSM continuation estimate, exercise decision and cashflow update
module lsm_exercise_eval
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH     = FP_WIDTH,
    parameter int QFRAC     = FP_QFRAC,
    parameter int N_SAMPLES = 10000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      beta_valid,
    output logic                      beta_ready,
    input  logic signed [3*WIDTH-1:0] beta_in,
    input  logic                      valid_in,
    output logic                      ready_out,
    input  logic signed [WIDTH-1:0]   s_in,
    input  logic signed [WIDTH-1:0]   payoff_in,
    input  logic signed [WIDTH-1:0]   cont_in,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic signed [WIDTH-1:0]   y_out,
    output logic                      exercise_out,
    output logic                      date_done
);

    localparam int CW = $clog2(N_SAMPLES + 1);
    localparam logic [CW-1:0] N_FULL = CW'(N_SAMPLES);
    localparam logic [CW-1:0] N_LAST = CW'(N_SAMPLES - 1);

    lsm_eval_state_e state;
    lsm_eval_state_e state_nxt;
    logic [CW-1:0]   in_cnt;
    logic [CW-1:0]   out_cnt;
    fx_t             beta0;
    fx_t             beta1;
    fx_t             beta2;
    logic            done_nxt;

    logic adv;
    logic in_fire;
    logic out_fire;
    logic beta_fire;

    logic v2;
    fx_t  c2;
    fx_t  pay2;
    fx_t  cont2;
    logic ex_c;

    // Single global stall: every stage moves only when the output slot is free or draining.
    assign adv       = !valid_out || ready_in;
    assign in_fire   = valid_in && ready_out;
    assign out_fire  = valid_out && ready_in;
    assign beta_fire = beta_valid && beta_ready;

    always_comb begin
        state_nxt  = state;
        beta_ready = 1'b0;
        ready_out  = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            WAIT_BETA: begin
                // Hold off a new coefficient set during the date_done pulse cycle.
                beta_ready = !date_done;
                if (beta_valid && !date_done) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                ready_out = adv && (in_cnt < N_FULL);
                if (in_fire && in_cnt == N_LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && out_cnt == N_LAST) begin
                    done_nxt  = 1'b1;
                    state_nxt = WAIT_BETA;
                end
            end
            default: state_nxt = WAIT_BETA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_BETA;
            date_done <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            beta0     <= '0;
            beta1     <= '0;
            beta2     <= '0;
        end else begin
            state     <= state_nxt;
            date_done <= done_nxt;
            if (beta_fire) begin
                beta0   <= beta_in[WIDTH-1:0];
                beta1   <= beta_in[2*WIDTH-1:WIDTH];
                beta2   <= beta_in[3*WIDTH-1:2*WIDTH];
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (in_fire) begin
                    in_cnt <= in_cnt + 1'b1;
                end
                if (out_fire) begin
                    out_cnt <= out_cnt + 1'b1;
                end
            end
        end
    end

    horner_quad_pipe #(
        .QFRAC(QFRAC)
    ) u_horner (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (adv),
        .in_valid (in_fire),
        .s        (s_in),
        .payoff   (payoff_in),
        .cont     (cont_in),
        .beta0    (beta0),
        .beta1    (beta1),
        .beta2    (beta2),
        .out_valid(v2),
        .c        (c2),
        .payoff_q (pay2),
        .cont_q   (cont2)
    );

    // Worthless paths are never exercised even when the regression predicts a loss.
    assign ex_c = (pay2 > fx_t'(0)) && (pay2 > c2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out    <= 1'b0;
            y_out        <= '0;
            exercise_out <= 1'b0;
        end else if (adv) begin
            valid_out <= v2;
            if (v2) begin
                exercise_out <= ex_c;
                y_out        <= ex_c ? pay2 : cont2;
            end
        end
    end

endmodule

// File: tb/tb_lsm_exercise_eval.sv
// tb/tb_lsm_exercise_eval.sv - directed self-checking bench with a behavioural scoreboard
module tb_lsm_exercise_eval;

    localparam int W  = 32;
    localparam int NS = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  beta_valid;
    logic                  beta_ready;
    logic signed [3*W-1:0] beta_in;
    logic                  valid_in;
    logic                  ready_out;
    logic signed [W-1:0]   s_in;
    logic signed [W-1:0]   payoff_in;
    logic signed [W-1:0]   cont_in;
    logic                  valid_out;
    logic                  ready_in;
    logic signed [W-1:0]   y_out;
    logic                  exercise_out;
    logic                  date_done;

    always #5 clk = ~clk;

    lsm_exercise_eval #(
        .WIDTH    (W),
        .QFRAC    (16),
        .N_SAMPLES(NS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .beta_valid  (beta_valid),
        .beta_ready  (beta_ready),
        .beta_in     (beta_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .s_in        (s_in),
        .payoff_in   (payoff_in),
        .cont_in     (cont_in),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .y_out       (y_out),
        .exercise_out(exercise_out),
        .date_done   (date_done)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;

    typedef struct {
        longint y;
        logic   ex;
    } exp_t;

    exp_t   exp_q[$];
    longint mb0, mb1, mb2;
    logic   prev_stall = 1'b0;
    longint held_y;
    logic   held_ex;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint satw(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic longint mulq(input longint a, input longint b);
        longint p;
        p = a * b;
        return satw(p >>> 16);
    endfunction

    function automatic longint model_c(input longint b0, input longint b1, input longint b2, input longint s);
        longint t;
        t = satw(b1 + mulq(b2, s));
        return satw(b0 + mulq(s, t));
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (beta_valid && beta_ready) begin
                mb0 = longint'($signed(beta_in[W-1:0]));
                mb1 = longint'($signed(beta_in[2*W-1:W]));
                mb2 = longint'($signed(beta_in[3*W-1:2*W]));
            end
            if (valid_in && ready_out) begin
                exp_t   e;
                longint c, p;
                c    = model_c(mb0, mb1, mb2, longint'(s_in));
                p    = longint'(payoff_in);
                e.ex = (p > 0) && (p > c);
                e.y  = e.ex ? p : longint'(cont_in);
                exp_q.push_back(e);
            end
            if (prev_stall) begin
                check("stall_valid_held", valid_out, 1);
                check("stall_y_held", y_out, held_y);
                check("stall_ex_held", exercise_out, held_ex);
            end
            if (valid_out && ready_in) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_output: got y=%0h with no pending path at %0t", y_out, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("y_out", y_out, e.y);
                    check("exercise_out", exercise_out, e.ex);
                end
            end
            if (valid_out && !ready_in) begin
                check("stall_ready_out", ready_out, 0);
            end
            prev_stall = valid_out && !ready_in;
            held_y     = longint'(y_out);
            held_ex    = exercise_out;
        end
    end

    task automatic load_beta(input int b0, input int b1, input int b2);
        logic got;
        got        = 1'b0;
        beta_in    = {b2, b1, b0};
        beta_valid = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = beta_ready;
            @(posedge clk);
            #1;
        end
        beta_valid = 1'b0;
        check("beta_accepted", got, 1);
    endtask

    task automatic send(input int s, input int p, input int c);
        logic got;
        got       = 1'b0;
        s_in      = s;
        payoff_in = p;
        cont_in   = c;
        valid_in  = 1'b1;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            got = ready_out;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        check("path_accepted", got, 1);
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = date_done;
        end
        check("date_done_seen", got, 1);
        check("beta_ready_on_done", beta_ready, 0);
        @(negedge clk);
        check("date_done_one_cycle", date_done, 0);
        check("beta_ready_after_done", beta_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_out();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = valid_out;
        end
        check("valid_out_seen", got, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n      = 1'b0;
        beta_valid = 1'b0;
        beta_in    = '0;
        valid_in   = 1'b0;
        s_in       = '0;
        payoff_in  = '0;
        cont_in    = '0;
        ready_in   = 1'b1;

        check("pin_c_basic", model_c(64'sh10000, 64'sh8000, 0, 64'sh20000), 64'sh20000);
        check("pin_c_neg", model_c(-64'sh10000, 0, 0, 64'sh12345), -64'sh10000);
        check("pin_c_sat", model_c(0, 0, 64'sh7FFFFFFF, 64'sh01000000), 64'sh7FFFFFFF);
        check("pin_c_floor", model_c(0, -1, 0, 64'sh8000), -1);
        check("pin_c_quad", model_c(64'sh10000, 64'sh8000, 64'sh4000, 64'sh30000), 64'sh4C000);

        repeat (2) @(negedge clk);
        check("rst_valid_out", valid_out, 0);
        check("rst_y_out", y_out, 0);
        check("rst_exercise_out", exercise_out, 0);
        check("rst_date_done", date_done, 0);
        check("rst_beta_ready", beta_ready, 1);
        check("rst_ready_out", ready_out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Date 1: exercise, continuation, tie, zero-price path.
        load_beta(32'h0001_0000, 32'h0000_8000, 0);
        send(32'h0002_0000, 32'h0003_0000, 32'h0000_4000);
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (valid_out) lat = k;
        end
        check("latency", lat, 3);
        @(posedge clk);
        #1;
        send(32'h0002_0000, 32'h0001_0000, 32'h0000_4000);
        send(32'h0002_0000, 32'h0002_0000, 32'h0000_5000);
        send(0, 32'h0001_8000, 32'h0000_6000);
        wait_done();

        // Date 2: negative C, non-positive payoffs, payoff equal to C; 5th path during DRAIN.
        load_beta(-32'sh10000, 0, 0);
        send(32'h0001_0000, 0, 32'h0000_1000);
        send(32'h0001_0000, -32'sh8000, 32'h0000_2000);
        send(32'h0001_0000, 32'h0001_0000, 32'h0000_3000);
        send(32'h0001_0000, -32'sh10000, 32'h0000_4000);
        valid_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("drain_ready_out", ready_out, 0);
        end
        @(posedge clk);
        #1 valid_in = 1'b0;
        wait_done();

        // Date 3: saturated C; output stalled while inputs are still arriving.
        ready_in = 1'b0;
        load_beta(0, 0, 32'h7FFF_FFFF);
        fork
            begin
                send(32'h0100_0000, 32'h7FFF_FFFF, 32'h0000_0111);
                send(32'h0100_0000, 32'h0001_0000, 32'h0000_0222);
                send(32'h0100_0000, 0, 32'h0000_0333);
                send(32'h0100_0000, -1, 32'h0000_0444);
            end
            begin
                wait_valid_out();
                repeat (5) @(posedge clk);
                #1 ready_in = 1'b1;
            end
        join
        wait_done();

        // Date 4: back-to-back paths, output stalled 5 cycles after the first result.
        load_beta(32'h0001_0000, 32'h0000_8000, 32'h0000_4000);
        fork
            begin
                send(32'h0001_0000, 32'h0002_0000, 32'h0000_0AAA);
                send(-32'sh20000, 32'h0000_8000, 32'h0000_0BBB);
                send(32'h0003_0000, 32'h0005_0000, 32'h0000_0CCC);
                send(32'h0000_8000, 32'h0001_4000, 32'h0000_0DDD);
            end
            begin
                wait_valid_out();
                @(posedge clk);
                #1 ready_in = 1'b0;
                repeat (5) @(posedge clk);
                #1 ready_in = 1'b1;
            end
        join
        wait_done();

        // Date 5: reset with paths in flight, then a clean date.
        ready_in = 1'b0;
        load_beta(32'h0001_0000, 0, 0);
        send(32'h0001_0000, 32'h0009_0000, 32'h0000_0123);
        send(32'h0001_0000, 32'h0000_1000, 32'h0000_0456);
        wait_valid_out();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid_out", valid_out, 0);
        check("midrst_beta_ready", beta_ready, 1);
        check("midrst_ready_out", ready_out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("postrst_no_stale", valid_out, 0);
        end
        @(posedge clk);
        #1;
        load_beta(32'h0002_0000, 0, 0);
        send(32'h0001_0000, 32'h0003_0000, 32'h0000_0777);
        send(32'h0001_0000, 32'h0002_0000, 32'h0000_0888);
        send(32'h0001_0000, 32'h0001_0000, 32'h0000_0999);
        send(32'h0001_0000, 32'h0002_0001, 32'h0000_0AAA);
        wait_done();

        repeat (2) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("outputs_total", n_out, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
